// File: rtl/r5_pkg.sv
// Shared definitions for the radix-5 FFT datapath: radix constant, default
// component width, complex sample type and group-index width helper.
package r5_pkg;

    localparam int R5     = 5;
    localparam int R5_DW  = 32;
    localparam int SCNT_W = 3;

    typedef struct packed {
        logic [R5_DW-1:0] re;
        logic [R5_DW-1:0] img;
    } r5_cplx_t;

    // Width of a group index for an n-point frame; never narrower than 1 bit.
    function automatic int grp_width(input int n);
        return (n / R5 > 1) ? $clog2(n / R5) : 1;
    endfunction

endpackage

// File: rtl/r5_input_collect_if.sv
// Sample-in / group-out bundle of the radix-5 input collector. The master
// drives samples and receives groups; the collector itself is the slave.
interface r5_input_collect_if
    import r5_pkg::*;
#(
    parameter int DW = R5_DW,
    parameter int N  = 25,
    parameter int GW = grp_width(N)
);

    logic               in_valid;
    logic               in_sof;
    logic [DW-1:0]      a_re;
    logic [DW-1:0]      a_img;
    logic               out_valid;
    logic               out_last;
    logic [GW-1:0]      out_group;
    logic [R5*DW-1:0]   x_re;
    logic [R5*DW-1:0]   x_img;
    logic               drop_err;

    modport master (
        output in_valid, in_sof, a_re, a_img,
        input  out_valid, out_last, out_group, x_re, x_img, drop_err
    );

    modport slave (
        input  in_valid, in_sof, a_re, a_img,
        output out_valid, out_last, out_group, x_re, x_img, drop_err
    );

endinterface

// File: rtl/r5_group_cnt.sv
// Sample-in-group and group-in-frame counters with start-of-frame resync.
// Strobes are combinational for the accepting cycle; the caller registers them.
module r5_group_cnt
    import r5_pkg::*;
#(
    parameter int N  = 25,
    parameter int GW = grp_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [SCNT_W-1:0] scnt,
    output logic [GW-1:0]     gcnt,
    output logic              done,
    output logic              last,
    output logic              drop
);

    localparam int NG = N / R5;

    logic [SCNT_W-1:0] scnt_reg;
    logic [GW-1:0]     gcnt_reg;

    // A sof sample always restarts the group, even when it would have been x4.
    assign done = in_valid && !in_sof && (scnt_reg == SCNT_W'(R5 - 1));
    assign drop = in_valid && in_sof && (scnt_reg != '0);
    assign last = (gcnt_reg == GW'(NG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_reg <= '0;
            gcnt_reg <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                scnt_reg <= SCNT_W'(1);
                gcnt_reg <= '0;
            end else if (done) begin
                scnt_reg <= '0;
                gcnt_reg <= last ? '0 : gcnt_reg + 1'b1;
            end else begin
                scnt_reg <= scnt_reg + 1'b1;
            end
        end
    end

    assign scnt = scnt_reg;
    assign gcnt = gcnt_reg;

endmodule

// File: rtl/r5_input_collect.sv
// Serial-to-parallel input stage of the radix-5 FFT: gathers five complex
// samples and presents them as one registered group with its frame index.
module r5_input_collect
    import r5_pkg::*;
#(
    parameter int DW = R5_DW,
    parameter int N  = 25,
    parameter int GW = grp_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    r5_input_collect_if.slave bus
);

    localparam int NSTAGE = R5 - 1;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] img;
    } sample_t;

    sample_t           in_sample;
    logic [SCNT_W-1:0] scnt;
    logic [GW-1:0]     gcnt;
    logic              grp_done;
    logic              grp_last;
    logic              grp_drop;

    logic [R5*DW-1:0]  x_re_next;
    logic [R5*DW-1:0]  x_img_next;
    logic [R5*DW-1:0]  x_re_reg;
    logic [R5*DW-1:0]  x_img_reg;
    logic [GW-1:0]     out_group_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              drop_err_reg;

    assign in_sample = '{re: bus.a_re, img: bus.a_img};

    r5_group_cnt #(
        .N  (N),
        .GW (GW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_sof   (bus.in_sof),
        .scnt     (scnt),
        .gcnt     (gcnt),
        .done     (grp_done),
        .last     (grp_last),
        .drop     (grp_drop)
    );

    // Stages 0..3 hold the first four samples; a sof sample always lands in stage 0.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        sample_t data_reg;
        logic    we;

        assign we = bus.in_valid && (bus.in_sof ? (gi == 0) : (scnt == SCNT_W'(gi)));

        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= '0;
            end else if (we) begin
                data_reg <= in_sample;
            end
        end

        assign x_re_next[gi*DW +: DW]  = data_reg.re;
        assign x_img_next[gi*DW +: DW] = data_reg.img;
    end

    // x4 bypasses staging so the group is presented one clock after its 5th sample.
    assign x_re_next[NSTAGE*DW +: DW]  = in_sample.re;
    assign x_img_next[NSTAGE*DW +: DW] = in_sample.img;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_re_reg      <= '0;
            x_img_reg     <= '0;
            out_group_reg <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            drop_err_reg  <= 1'b0;
        end else begin
            out_valid_reg <= grp_done;
            out_last_reg  <= grp_done && grp_last;
            drop_err_reg  <= grp_drop;
            if (grp_done) begin
                x_re_reg      <= x_re_next;
                x_img_reg     <= x_img_next;
                out_group_reg <= gcnt;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_group = out_group_reg;
    assign bus.x_re      = x_re_reg;
    assign bus.x_img     = x_img_reg;
    assign bus.drop_err  = drop_err_reg;

endmodule

// File: tb/tb_r5_input_collect.sv
// Directed scoreboard bench for r5_input_collect: a 25-point/32-bit instance
// and a 5-point/16-bit instance sharing one clock and reset.
module tb_r5_input_collect;

    typedef struct {
        logic [159:0] re;
        logic [159:0] img;
        logic [7:0]   grp;
        logic         last;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rst_q = 1'b0;
    bit   armed = 1'b0;
    int   cycle = 0;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   dq0[$];
    int   dq1[$];

    logic [31:0]  m_re  [2][4];
    logic [31:0]  m_img [2][4];
    int           m_scnt[2];
    int           m_gcnt[2];
    logic [159:0] held_re [2];
    logic [159:0] held_img[2];

    r5_input_collect_if #(.DW(32), .N(25)) b0 ();
    r5_input_collect_if #(.DW(16), .N(5))  b1 ();

    r5_input_collect #(.DW(32), .N(25)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    r5_input_collect #(.DW(16), .N(5))  u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        rst_q <= rst;
        if (rst) armed <= 1'b1;
    end

    task automatic chk(input int d, input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_scnt[d] = 0;
            m_gcnt[d] = 0;
        end
    endtask

    // Reference behaviour: push the expected group/drop when the stimulus is driven.
    task automatic model(input int d, input logic [31:0] re, input logic [31:0] im, input bit sof);
        int          dw   = (d == 1) ? 16 : 32;
        int          ng   = (d == 1) ? 1 : 5;
        logic [31:0] mask = (d == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        exp_t        e;
        if (sof) begin
            if (m_scnt[d] != 0) begin
                if (d == 0) dq0.push_back(cycle + 1);
                else        dq1.push_back(cycle + 1);
            end
            m_re[d][0]  = re;
            m_img[d][0] = im;
            m_scnt[d]   = 1;
            m_gcnt[d]   = 0;
        end else if (m_scnt[d] < 4) begin
            m_re[d][m_scnt[d]]  = re;
            m_img[d][m_scnt[d]] = im;
            m_scnt[d]++;
        end else begin
            e.re  = '0;
            e.img = '0;
            for (int i = 0; i < 4; i++) begin
                e.re  |= 160'(m_re[d][i] & mask) << (i * dw);
                e.img |= 160'(m_img[d][i] & mask) << (i * dw);
            end
            e.re  |= 160'(re & mask) << (4 * dw);
            e.img |= 160'(im & mask) << (4 * dw);
            e.grp  = 8'(m_gcnt[d]);
            e.last = (m_gcnt[d] == ng - 1);
            e.cyc  = cycle + 1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_scnt[d] = 0;
            m_gcnt[d] = (m_gcnt[d] == ng - 1) ? 0 : m_gcnt[d] + 1;
        end
    endtask

    task automatic send(input int d, input logic [31:0] re, input logic [31:0] im, input bit sof);
        @(negedge clk);
        b0.in_valid = (d == 0);
        b1.in_valid = (d == 1);
        b0.in_sof   = sof;
        b1.in_sof   = sof;
        b0.a_re     = re;
        b0.a_img    = im;
        b1.a_re     = re[15:0];
        b1.a_img    = im[15:0];
        model(d, re, im, sof);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            b0.in_valid = 1'b0;
            b1.in_valid = 1'b0;
            b0.in_sof   = 1'b0;
            b1.in_sof   = 1'b0;
        end
    endtask

    // Reset with a sof sample driven alongside to exercise reset priority.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst         = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_sof   = 1'b1;
        b0.a_re     = 32'hDEAD_BEEF;
        b0.a_img    = 32'h1234_5678;
        model_reset();
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        b0.in_valid = 1'b0;
        b0.in_sof   = 1'b0;
    endtask

    task automatic monitor(input int d, input logic v, input logic l, input logic [7:0] g,
                           input logic [159:0] xr, input logic [159:0] xi, input logic de);
        exp_t e;
        int   dc;
        int   qs;
        int   ds;
        if (rst_q) begin
            chk(d, "reset out_valid", 160'(v), 160'(0));
            chk(d, "reset out_last", 160'(l), 160'(0));
            chk(d, "reset out_group", 160'(g), 160'(0));
            chk(d, "reset x_re", xr, '0);
            chk(d, "reset x_img", xi, '0);
            chk(d, "reset drop_err", 160'(de), 160'(0));
            held_re[d]  = '0;
            held_img[d] = '0;
            return;
        end
        if (v) begin
            qs = (d == 0) ? q0.size() : q1.size();
            chk(d, "group expected", 160'(qs != 0), 160'(1));
            if (qs != 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                $display("dut%0d cycle %0d group %0d last %0b x_re %0h x_img %0h",
                         d, cycle, g, l, xr, xi);
                chk(d, "x_re", xr, e.re);
                chk(d, "x_img", xi, e.img);
                chk(d, "out_group", 160'(g), 160'(e.grp));
                chk(d, "out_last", 160'(l), 160'(e.last));
                chk(d, "latency", 160'(cycle), 160'(e.cyc));
            end
            held_re[d]  = xr;
            held_img[d] = xi;
        end else begin
            chk(d, "out_last idle", 160'(l), 160'(0));
            chk(d, "x_re hold", xr, held_re[d]);
            chk(d, "x_img hold", xi, held_img[d]);
        end
        if (de) begin
            ds = (d == 0) ? dq0.size() : dq1.size();
            chk(d, "drop expected", 160'(ds != 0), 160'(1));
            if (ds != 0) begin
                if (d == 0) dc = dq0.pop_front();
                else        dc = dq1.pop_front();
                $display("dut%0d cycle %0d drop_err", d, cycle);
                chk(d, "drop cycle", 160'(cycle), 160'(dc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            monitor(0, b0.out_valid, b0.out_last, 8'(b0.out_group),
                    160'(b0.x_re), 160'(b0.x_img), b0.drop_err);
            monitor(1, b1.out_valid, b1.out_last, 8'(b1.out_group),
                    160'(b1.x_re), 160'(b1.x_img), b1.drop_err);
        end
    end

    initial begin
        b0.in_valid = 1'b0; b0.in_sof = 1'b0; b0.a_re = '0; b0.a_img = '0;
        b1.in_valid = 1'b0; b1.in_sof = 1'b0; b1.a_re = '0; b1.a_img = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single frame streamed at one sample per cycle.
        for (int k = 0; k < 25; k++) send(0, 32'(k), 32'(-k), k == 0);
        idle(4);

        // Same frame with 3-cycle gaps after k=2 and k=13.
        for (int k = 0; k < 25; k++) begin
            send(0, 32'(k), 32'(-k), k == 0);
            if (k == 2 || k == 13) idle(3);
        end
        idle(4);

        // sof mid-group discards the partial group and resyncs to group 0.
        for (int k = 0; k < 8; k++) send(0, 32'(k), 32'(-k), k == 0);
        for (int k = 100; k < 105; k++) send(0, 32'(k), 32'(-k), k == 100);
        idle(4);

        // Reset mid-group, then an un-flagged group is group 0.
        for (int k = 60; k < 63; k++) send(0, 32'(k), 32'(-k), 1'b0);
        do_reset(3);
        for (int k = 50; k < 55; k++) send(0, 32'(k), 32'(-k), 1'b0);
        idle(4);

        // Two back-to-back frames; the second sof arrives on a group boundary.
        for (int k = 0; k < 50; k++) send(0, 32'(k + 200), 32'(-k), k == 0 || k == 25);
        idle(4);

        // Five-point 16-bit instance: every group is last, sofs on group boundaries.
        for (int k = 0; k < 15; k++)
            send(1, 32'(k * 4097 + 32'hABCD_0000), 32'(-k - 1000), k == 0 || k == 10);
        idle(2);
        for (int k = 0; k < 3; k++) send(1, 32'(k + 7), 32'(k), k == 0);
        send(1, 32'h0000_8001, 32'h0000_7FFF, 1'b1);
        for (int k = 0; k < 4; k++) send(1, 32'(k + 300), 32'(-k), 1'b0);
        idle(10);

        chk(0, "groups outstanding", 160'(q0.size()), 160'(0));
        chk(1, "groups outstanding", 160'(q1.size()), 160'(0));
        chk(0, "drops outstanding", 160'(dq0.size()), 160'(0));
        chk(1, "drops outstanding", 160'(dq1.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/r5_input_collect.md
# r5_input_collect

Serial-to-parallel input stage for the radix-5 FFT datapath. It takes one complex sample per valid cycle, groups five consecutive samples, and presents each group in parallel to the radix-5 butterfly. The butterfly's outputs feed the `buf_6` alignment delay line. The block also tracks the group index within an N-point frame, so downstream twiddle and control logic can use it.

## Interface
Parameters:
- `DW`, 32, width of each real/imaginary component (two's complement, passed through unmodified)
- `N`, 25, frame length in samples; must be a multiple of 5 and ≥ 5
- `GW`, `$clog2(N/5)` (min 1), width of group index

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  `a_re`/`a_img` carry a sample this cycle
- `in_sof`  in  1  start of frame; only meaningful with `in_valid`
- `a_re`  in  DW  sample real part
- `a_img`  in  DW  sample imaginary part
- `out_valid`  out  1  one-cycle pulse: new group on `x_re`/`x_img`
- `out_last`  out  1  with `out_valid`: group is the last of the frame
- `out_group`  out  GW  group index 0..N/5-1 of the presented group
- `x_re`  out  5*DW  x0 in `[DW-1:0]` … x4 in `[5*DW-1:4*DW]`, real parts
- `x_img`  out  5*DW  same packing, imaginary parts
- `drop_err`  out  1  one-cycle pulse: partial group discarded by `in_sof`

## Operation
- Sample counter `scnt` (0..4) and group counter `gcnt` (0..N/5-1).
- Four staging registers hold samples 0..3 of the current group.
- On accepted sample (`in_valid`=1):
  - `scnt`<4: store into stage[`scnt`], `scnt`++.
  - `scnt`==4: load `x_*` with stage[0..3] plus the current sample as x4. Set `out_group`=`gcnt` and `out_last`=(`gcnt`==N/5-1). Pulse `out_valid`. Set `scnt`=0. `gcnt` increments, wrapping to 0 after N/5-1.
- `in_valid`=0: all counters and stages hold; gaps of any length are allowed mid-group.
- `in_sof` with `in_valid`:
  - The sample becomes x0 of group 0: stage[0]←sample, `scnt`←1, `gcnt`←0.
  - If `scnt`≠0 at that time, pulse `drop_err`; the partial group is never output.
  - `in_sof` when `scnt`==0 is legal and silent (`gcnt` still forced to 0).
- `in_sof` without `in_valid` is ignored.
- Continuous streaming at one sample/cycle needs no stall. `x_*` holds its value until the next group completes, which is at least 5 cycles away.
- There is no ready input; the downstream consumer must take a group on the `out_valid` cycle.

## Timing
- Latency: `out_valid` is asserted in the cycle after the 5th sample's `in_valid` edge (1 clock, registered).
- `out_valid`, `out_last` and `drop_err` are single-cycle pulses. `out_last` is 0 whenever `out_valid`=0.
- Reset values: `out_valid`=0, `out_last`=0, `drop_err`=0, `out_group`=0, `x_re`=0, `x_img`=0, `scnt`=0, `gcnt`=0, stages=0.
- `rst` mid-group discards the partial group; no `drop_err` is raised. The first sample after reset is x0 of group 0 whether or not `in_sof` is set.
- `rst` has priority over `in_valid`/`in_sof` in the same cycle.
- In steady streaming, `out_valid` has period 5 and `out_last` has period N.

## Structure
- Shared package `r5_pkg`: `R5`=5, default `DW`=32, and a complex sample typedef `{re, img}` reused by the butterfly and `buf_6`-style delay stages.
- One natural sub-module, `r5_group_cnt`: `scnt`/`gcnt` counters with sof resync and wrap, producing `last` and `drop`. Staging and output registers stay in the top.

## Test plan
- Reset, then stream 25 samples with re=k, img=-k (k=0..24) at 1/cycle and `in_sof` on k=0 -> 5 `out_valid` pulses 5 cycles apart. Group g has x_i re=5g+i, img=-(5g+i); `out_group`=0..4; `out_last` only on group 4; `drop_err` never.
- Same stream with `in_valid` deasserted for 3 cycles after k=2 and k=13 -> identical group contents; pulses delayed by the gaps.
- Send k=0..7, then `in_sof` with re=100 followed by 4 more samples -> group 0 (re 0..4) is output. `drop_err` pulses once at the sof sample. The next group is re 100,101,… with `out_group`=0.
- Assert `rst` after 3 samples of a group, then send 5 samples re=50..54 -> all outputs 0 during reset. Exactly one group re 50..54 with `out_group`=0; no `drop_err`.
- Send two back-to-back frames (50 samples, `in_sof` at 0 and 25) -> `gcnt` wraps 4→0 and `out_last` appears at the 5th and 10th groups. `in_sof` at scnt==0 raises no `drop_err`.
- Run with `N`=5 and `DW`=16 -> every group has `out_last`=1 and `out_group`=0; data is packed correctly at 16-bit width.
